// File: rtl/dmem_dual_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_dual_port_arbiter_if
// Bus bundle between the two pipeline MEM stages, the data-memory arbiter and
// the single-ported data memory.
//   Pipe side  : req/we/addr/wdata/funct3/pc/flush for pipe1 and pipe2 in,
//                rdata1_o/rdata2_o and stall_mem_o back out.
//   Memory side: mem_req/we/addr/wdata/funct3 out, mem_ready/mem_rdata in.
// Modports:
//   slave  - the arbiter
//   master - the surrounding pipeline and memory (or a testbench)
// ---------------------------------------------------------------------------
interface dmem_dual_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // pipe1 MEM stage
    logic              req1_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [2:0]        funct3_1_i;
    logic [31:0]       pc1_i;
    logic              flush1_i;
    // pipe2 MEM stage
    logic              req2_i;
    logic              we2_i;
    logic [ADDR_W-1:0] addr2_i;
    logic [DATA_W-1:0] wdata2_i;
    logic [2:0]        funct3_2_i;
    logic [31:0]       pc2_i;
    logic              flush2_i;
    // results back to the pipelines
    logic [DATA_W-1:0] rdata1_o;
    logic [DATA_W-1:0] rdata2_o;
    logic              stall_mem_o;
    // data memory
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [2:0]        mem_funct3_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  req1_i, we1_i, addr1_i, wdata1_i, funct3_1_i, pc1_i, flush1_i,
        input  req2_i, we2_i, addr2_i, wdata2_i, funct3_2_i, pc2_i, flush2_i,
        output rdata1_o, rdata2_o, stall_mem_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport master (
        output req1_i, we1_i, addr1_i, wdata1_i, funct3_1_i, pc1_i, flush1_i,
        output req2_i, we2_i, addr2_i, wdata2_i, funct3_2_i, pc2_i, flush2_i,
        input  rdata1_o, rdata2_o, stall_mem_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/dmem_dual_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_dual_port_arbiter
// Shares one single-ported data memory between the MEM stages of pipeline 1
// and pipeline 2. Same-cycle accesses are serialised in program order (lower
// PC first, pipe1 on equal PC); both MEM stages stay stalled until every
// access of the issue pair has completed, then released for one cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     pipe requests/flushes in, per-pipe load data and
//                   stall_mem_o out, dmem request/response
//   conflict_cnt_o  issue pairs that carried two pending accesses
//   stall_cnt_o     cycles with stall_mem_o high
//
// Configuration macro: DMEM_ARB_PERF_EN
//   defined   - both performance counters implemented (wrap at 2^CNT_W)
//   undefined - counters absent, outputs tied to zero
// ---------------------------------------------------------------------------
module dmem_dual_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dmem_dual_port_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]           conflict_cnt_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        RELEASE
    } arbStateT;

    arbStateT state;
    arbStateT nextState;

    // Requests captured at the IDLE->FIRST edge; later input changes are ignored.
    logic              cap1We,     cap2We;
    logic [ADDR_W-1:0] cap1Addr,   cap2Addr;
    logic [DATA_W-1:0] cap1Wdata,  cap2Wdata;
    logic [2:0]        cap1Funct3, cap2Funct3;

    logic firstPipe2;   // pipe2 is served in FIRST, pipe1 (if queued) in SECOND
    logic queued;       // a second access is still owed for this issue pair
    logic kill1, kill2; // pipe flushed while its access was outstanding

    logic              pend1, pend2;
    logic              curPipe2;
    logic              curWe;
    logic              queuedFlush;
    logic              stall;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [2:0]        memFunct3;
    logic [DATA_W-1:0] rdata1, rdata2;

    assign pend1 = bus.req1_i & ~bus.flush1_i;
    assign pend2 = bus.req2_i & ~bus.flush2_i;

    // Pipe that owns dmem this cycle: the older one in FIRST, the other in SECOND.
    assign curPipe2    = (state == SECOND) ? ~firstPipe2 : firstPipe2;
    assign curWe       = curPipe2 ? cap2We : cap1We;
    assign queuedFlush = firstPipe2 ? bus.flush1_i : bus.flush2_i;

    // State register. Reset returns to IDLE asynchronously, so mem_req_o,
    // which decodes from state, drops without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state <= nextState;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        nextState = state;
        stall     = 1'b0;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        memFunct3 = '0;
        case (state)
            IDLE: begin
                stall = pend1 | pend2;
                if (pend1 | pend2) begin
                    nextState = FIRST;
                end
            end
            FIRST: begin
                stall  = 1'b1;
                memReq = 1'b1;
                if (bus.mem_ready_i) begin
                    // A queued access flushed in this same cycle is dropped too.
                    nextState = (queued && !queuedFlush) ? SECOND : RELEASE;
                end
            end
            SECOND: begin
                stall  = 1'b1;
                memReq = 1'b1;
                if (bus.mem_ready_i) begin
                    nextState = RELEASE;
                end
            end
            RELEASE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (memReq) begin
            memWe     = curWe;
            memAddr   = curPipe2 ? cap2Addr   : cap1Addr;
            memWdata  = curPipe2 ? cap2Wdata  : cap1Wdata;
            memFunct3 = curPipe2 ? cap2Funct3 : cap1Funct3;
        end
    end

    // Request payload. Only ever read while memReq is high, after a capture.
    // NOTE: pure datapath registers carry no reset; outputs are gated by memReq instead.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            cap1We     <= bus.we1_i;
            cap1Addr   <= bus.addr1_i;
            cap1Wdata  <= bus.wdata1_i;
            cap1Funct3 <= bus.funct3_1_i;
            cap2We     <= bus.we2_i;
            cap2Addr   <= bus.addr2_i;
            cap2Wdata  <= bus.wdata2_i;
            cap2Funct3 <= bus.funct3_2_i;
        end
    end

    // Ordering and flush bookkeeping for the current issue pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            firstPipe2 <= 1'b0;
            queued     <= 1'b0;
            kill1      <= 1'b0;
            kill2      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Older access first; equal PCs resolve to pipe1.
                    firstPipe2 <= pend2 & (~pend1 | (bus.pc2_i < bus.pc1_i));
                    queued     <= pend1 & pend2;
                    kill1      <= 1'b0;
                    kill2      <= 1'b0;
                end
                FIRST, SECOND: begin
                    if (state == FIRST && queuedFlush) begin
                        queued <= 1'b0;
                    end
                    kill1 <= kill1 | bus.flush1_i;
                    kill2 <= kill2 | bus.flush2_i;
                end
                default: ;
            endcase
        end
    end

    // Load data for the writeback registers; held until the pipe's next load.
    // An access that completes after its pipe was flushed still finishes in
    // dmem, but its load data is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (memReq && bus.mem_ready_i && !curWe) begin
            if (curPipe2) begin
                if (!(kill2 || bus.flush2_i)) begin
                    rdata2 <= bus.mem_rdata_i;
                end
            end else begin
                if (!(kill1 || bus.flush1_i)) begin
                    rdata1 <= bus.mem_rdata_i;
                end
            end
        end
    end

    assign bus.rdata1_o     = rdata1;
    assign bus.rdata2_o     = rdata2;
    assign bus.stall_mem_o  = stall;
    assign bus.mem_req_o    = memReq;
    assign bus.mem_we_o     = memWe;
    assign bus.mem_addr_o   = memAddr;
    assign bus.mem_wdata_o  = memWdata;
    assign bus.mem_funct3_o = memFunct3;

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] conflictCnt;
    logic [CNT_W-1:0] stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflictCnt <= '0;
            stallCnt    <= '0;
        end else begin
            if (state == IDLE && pend1 && pend2) begin
                conflictCnt <= conflictCnt + 1'b1;
            end
            if (stall) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    assign conflict_cnt_o = conflictCnt;
    assign stall_cnt_o    = stallCnt;
`else
    assign conflict_cnt_o = '0;
    assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_dmem_dual_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_dual_port_arbiter
// Directed bench for dmem_dual_port_arbiter. A small word-addressed memory
// model answers dmem requests after a programmable number of wait cycles.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or shortly after it.
// ---------------------------------------------------------------------------
module tb_dmem_dual_port_arbiter;

`ifdef DMEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] conflict_cnt_o;
    logic [31:0] stall_cnt_o;

    int assertions = 0;
    int failures   = 0;

    dmem_dual_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_dual_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .conflict_cnt_o (conflict_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // ---------------- data memory model ----------------
    logic [31:0] memArr [0:1023];
    int          readyDelay = 0;
    int          waitCnt;
    int          accCount = 0;
    logic [32:0] accLog [$];   // {we, addr} of each completed access, in order

    assign bus.mem_ready_i = bus.mem_req_o && (waitCnt >= readyDelay);
    assign bus.mem_rdata_i = memArr[bus.mem_addr_o[11:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= 0;
        end else if (bus.mem_req_o) begin
            if (bus.mem_ready_i) begin
                waitCnt  <= 0;
                accCount <= accCount + 1;
                accLog.push_back({bus.mem_we_o, bus.mem_addr_o});
                if (bus.mem_we_o) memArr[bus.mem_addr_o[11:2]] <= bus.mem_wdata_o;
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end
    end

    // ---------------- stimulus helper ----------------
    // Presents one issue pair for a cycle, optionally flushes pipe2 while the
    // first access is in flight, and counts the cycles stall_mem_o stays high
    // (bounded; a hang shows up as an oversized count).
    task automatic issue(input logic r1, input logic w1, input logic [31:0] a1, d1, p1,
                         input logic r2, input logic w2, input logic [31:0] a2, d2, p2,
                         input bit fl2, output int cyc);
        @(negedge clk);
        bus.req1_i = r1; bus.we1_i = w1; bus.addr1_i = a1; bus.wdata1_i = d1; bus.pc1_i = p1;
        bus.req2_i = r2; bus.we2_i = w2; bus.addr2_i = a2; bus.wdata2_i = d2; bus.pc2_i = p2;
        #1 cyc = bus.stall_mem_o ? 1 : 0;
        @(posedge clk);
        #1;
        bus.req1_i = 1'b0;
        bus.req2_i = 1'b0;
        if (fl2) bus.flush2_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.stall_mem_o) cyc++;
            else break;
        end
        bus.flush2_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        assertions++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_funct3_o} !== 70'd0) begin
            $display("FAIL reset_mem_outputs: got req=%b addr=%h, expected all zero", bus.mem_req_o, bus.mem_addr_o);
            failures++;
        end
        assertions++;
        if ({bus.rdata1_o, bus.rdata2_o} !== 64'd0) begin
            $display("FAIL reset_rdata: got %h/%h, expected 0/0", bus.rdata1_o, bus.rdata2_o);
            failures++;
        end
        assertions++;
        if ({conflict_cnt_o, stall_cnt_o} !== 64'd0) begin
            $display("FAIL reset_counters: got %0d/%0d, expected 0/0", conflict_cnt_o, stall_cnt_o);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        assertions++;
        if (bus.stall_mem_o !== 1'b0) begin
            $display("FAIL idle_stall: got %b, expected 0", bus.stall_mem_o);
            failures++;
        end
    endtask

    task automatic test_single_load();
        int cyc;
        issue(1'b1, 1'b0, 32'h100, 32'h0, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, cyc);
        assertions++;
        if (cyc !== 2) begin
            $display("FAIL single_load_stall: got %0d cycles, expected 2", cyc);
            failures++;
        end
        assertions++;
        if (bus.rdata1_o !== 32'hDEADBEEF) begin
            $display("FAIL single_load_rdata1: got %h, expected deadbeef", bus.rdata1_o);
            failures++;
        end
        assertions++;
        if (stall_cnt_o !== (PERF ? 32'd2 : 32'd0)) begin
            $display("FAIL single_load_stall_cnt: got %0d, expected %0d", stall_cnt_o, PERF ? 2 : 0);
            failures++;
        end
    endtask

    task automatic test_store_load_pair();
        int cyc;
        accLog.delete();
        issue(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, 32'h24, 1'b0, cyc);
        assertions++;
        if (cyc !== 3) begin
            $display("FAIL pair_stall: got %0d cycles, expected 3", cyc);
            failures++;
        end
        assertions++;
        if (accLog.size() !== 2 || accLog[0] !== {1'b1, 32'h40}) begin
            $display("FAIL pair_store_first: got %0d accesses, first %h, expected 2 and 100000040",
                     accLog.size(), accLog.size() > 0 ? accLog[0] : 33'h0);
            failures++;
        end
        assertions++;
        if (bus.rdata2_o !== 32'hCAFEF00D) begin
            $display("FAIL pair_forward_rdata2: got %h, expected cafef00d", bus.rdata2_o);
            failures++;
        end
        assertions++;
        if ({conflict_cnt_o, stall_cnt_o} !== (PERF ? {32'd1, 32'd5} : 64'd0)) begin
            $display("FAIL pair_counters: got %0d/%0d, expected %0d/%0d", conflict_cnt_o, stall_cnt_o,
                     PERF ? 1 : 0, PERF ? 5 : 0);
            failures++;
        end
    endtask

    task automatic test_order_by_pc();
        int cyc;
        accLog.delete();
        issue(1'b1, 1'b0, 32'h200, 32'h0, 32'h14, 1'b1, 1'b0, 32'h300, 32'h0, 32'h10, 1'b0, cyc);
        assertions++;
        if (accLog.size() !== 2 || accLog[0] !== {1'b0, 32'h300}) begin
            $display("FAIL order_pipe2_first: got %0d accesses, first %h, expected 2 and 000000300",
                     accLog.size(), accLog.size() > 0 ? accLog[0] : 33'h0);
            failures++;
        end
        assertions++;
        if ({bus.rdata1_o, bus.rdata2_o} !== {32'h11111111, 32'h22222222}) begin
            $display("FAIL order_rdata: got %h/%h, expected 11111111/22222222", bus.rdata1_o, bus.rdata2_o);
            failures++;
        end
        assertions++;
        if ({conflict_cnt_o, stall_cnt_o} !== (PERF ? {32'd2, 32'd8} : 64'd0)) begin
            $display("FAIL order_counters: got %0d/%0d, expected %0d/%0d", conflict_cnt_o, stall_cnt_o,
                     PERF ? 2 : 0, PERF ? 8 : 0);
            failures++;
        end
        assertions++;
        if (cyc !== 3) begin
            $display("FAIL order_stall: got %0d cycles, expected 3", cyc);
            failures++;
        end
    endtask

    task automatic test_flush_queued();
        int cyc;
        accLog.delete();
        issue(1'b1, 1'b0, 32'h200, 32'h0, 32'h50, 1'b1, 1'b0, 32'h40, 32'h0, 32'h54, 1'b1, cyc);
        assertions++;
        if (accLog.size() !== 1 || accLog[0] !== {1'b0, 32'h200}) begin
            $display("FAIL flush_dropped: got %0d accesses, first %h, expected 1 and 000000200",
                     accLog.size(), accLog.size() > 0 ? accLog[0] : 33'h0);
            failures++;
        end
        assertions++;
        if (cyc !== 2) begin
            $display("FAIL flush_stall: got %0d cycles, expected 2", cyc);
            failures++;
        end
        assertions++;
        if (bus.rdata2_o !== 32'h22222222) begin
            $display("FAIL flush_rdata2_kept: got %h, expected 22222222", bus.rdata2_o);
            failures++;
        end
    endtask

    task automatic test_ready_hold();
        readyDelay = 5;
        @(negedge clk);
        bus.req1_i = 1'b1; bus.we1_i = 1'b1; bus.addr1_i = 32'h500;
        bus.wdata1_i = 32'h5555AAAA; bus.pc1_i = 32'h40;
        @(posedge clk);
        #1;
        // Inputs wander after capture; the dmem fields must not follow them.
        bus.req1_i = 1'b0; bus.addr1_i = 32'h7FC; bus.wdata1_i = 32'h0BADF00D; bus.we1_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            assertions++;
            if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.stall_mem_o}
                    !== {1'b1, 1'b1, 32'h500, 32'h5555AAAA, 1'b1}) begin
                $display("FAIL hold_cycle%0d: got req=%b we=%b addr=%h wdata=%h stall=%b, expected 1 1 500 5555aaaa 1",
                         i, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.stall_mem_o);
                failures++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.stall_mem_o) break;
        end
        assertions++;
        if (bus.stall_mem_o !== 1'b0) begin
            $display("FAIL hold_release: got stall=%b, expected 0", bus.stall_mem_o);
            failures++;
        end
        assertions++;
        if (memArr[32'h500 >> 2] !== 32'h5555AAAA) begin
            $display("FAIL hold_store_data: got %h, expected 5555aaaa", memArr[32'h500 >> 2]);
            failures++;
        end
        readyDelay = 0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        accLog.delete();
        // Two stores to one address: pipe1 is older, pipe2's data must remain.
        issue(1'b1, 1'b1, 32'h80, 32'hAAAA0001, 32'h30, 1'b1, 1'b1, 32'h80, 32'hBBBB0002, 32'h34, 1'b0, cyc);
        assertions++;
        if (memArr[32'h80 >> 2] !== 32'hBBBB0002) begin
            $display("FAIL b2b_younger_store: got %h, expected bbbb0002", memArr[32'h80 >> 2]);
            failures++;
        end
        issue(1'b1, 1'b0, 32'h80, 32'h0, 32'h38, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, cyc);
        assertions++;
        if ({bus.rdata1_o, bus.rdata2_o} !== {32'hBBBB0002, 32'h22222222}) begin
            $display("FAIL b2b_rdata: got %h/%h, expected bbbb0002/22222222", bus.rdata1_o, bus.rdata2_o);
            failures++;
        end
        // Equal PCs resolve to pipe1.
        accLog.delete();
        issue(1'b1, 1'b0, 32'h100, 32'h0, 32'h60, 1'b1, 1'b0, 32'h200, 32'h0, 32'h60, 1'b0, cyc);
        assertions++;
        if (accLog.size() !== 2 || accLog[0] !== {1'b0, 32'h100}) begin
            $display("FAIL equal_pc_pipe1_first: got %0d accesses, first %h, expected 2 and 000000100",
                     accLog.size(), accLog.size() > 0 ? accLog[0] : 33'h0);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  found;
        int  cyc;
        readyDelay = 2;
        base  = accCount;
        found = 1'b0;
        @(negedge clk);
        bus.req1_i = 1'b1; bus.we1_i = 1'b0; bus.addr1_i = 32'h100; bus.pc1_i = 32'h70;
        bus.req2_i = 1'b1; bus.we2_i = 1'b0; bus.addr2_i = 32'h300; bus.pc2_i = 32'h74;
        @(posedge clk);
        #1;
        bus.req1_i = 1'b0;
        bus.req2_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (accCount == base + 1 && bus.mem_req_o) begin
                found = 1'b1;
                break;
            end
        end
        assertions++;
        if (found !== 1'b1) begin
            $display("FAIL midreset_reach_second: got found=%b, expected 1", found);
            failures++;
        end
        rst_n = 1'b0;
        #1;
        assertions++;
        if ({bus.mem_req_o, bus.stall_mem_o} !== 2'b00) begin
            $display("FAIL midreset_req_drop: got req=%b stall=%b, expected 0 0", bus.mem_req_o, bus.stall_mem_o);
            failures++;
        end
        assertions++;
        if ({bus.rdata1_o, bus.rdata2_o} !== 64'd0) begin
            $display("FAIL midreset_rdata: got %h/%h, expected 0/0", bus.rdata1_o, bus.rdata2_o);
            failures++;
        end
        assertions++;
        if ({conflict_cnt_o, stall_cnt_o} !== 64'd0) begin
            $display("FAIL midreset_counters: got %0d/%0d, expected 0/0", conflict_cnt_o, stall_cnt_o);
            failures++;
        end
        readyDelay = 0;
        @(negedge clk);
        rst_n = 1'b1;
        // Back in IDLE: a fresh single load behaves normally.
        issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h80, 1'b0, cyc);
        assertions++;
        if (cyc !== 2 || bus.rdata2_o !== 32'h22222222) begin
            $display("FAIL midreset_recover: got %0d cycles rdata2=%h, expected 2 and 22222222", cyc, bus.rdata2_o);
            failures++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) memArr[i] = 32'h0;
        memArr[32'h100 >> 2] = 32'hDEADBEEF;
        memArr[32'h200 >> 2] = 32'h11111111;
        memArr[32'h300 >> 2] = 32'h22222222;
        bus.req1_i = 1'b0; bus.we1_i = 1'b0; bus.addr1_i = '0; bus.wdata1_i = '0;
        bus.funct3_1_i = 3'b010; bus.pc1_i = '0; bus.flush1_i = 1'b0;
        bus.req2_i = 1'b0; bus.we2_i = 1'b0; bus.addr2_i = '0; bus.wdata2_i = '0;
        bus.funct3_2_i = 3'b010; bus.pc2_i = '0; bus.flush2_i = 1'b0;

        test_reset();
        test_single_load();
        test_store_load_pair();
        test_order_by_pc();
        test_flush_queued();
        test_ready_hold();
        test_back_to_back();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
